// File: rtl/divider_seq_8_bit.sv
// Sequential unsigned restoring divider: one quotient bit per clock by trial subtraction,
// with a start/busy/done handshake and registered quotient, remainder and div_by_zero.
module divider_seq_8_bit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] q_reg, q_nxt;
    logic [WIDTH:0]   r_reg, r_nxt;
    logic [WIDTH-1:0] d_reg, d_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic             busy_nxt, done_nxt, dbz_nxt;
    logic [WIDTH-1:0] quotient_nxt, remainder_nxt;

    logic             div_zero;
    logic [WIDTH:0]   shifted, trial, r_step;
    logic [WIDTH-1:0] q_step;

    // One restoring step: shift in the next dividend bit and try to subtract the divisor.
    always_comb begin
        div_zero = (divisor == '0);
        shifted  = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        trial    = shifted - {1'b0, d_reg};
        r_step   = trial[WIDTH] ? shifted : trial;
        q_step   = {q_reg[WIDTH-2:0], ~trial[WIDTH]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a start is accepted from IDLE and from DONE (back-to-back divides).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = div_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt = div_zero ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and output next values; results only move on the edge that enters DONE.
    always_comb begin
        q_nxt         = q_reg;
        r_nxt         = r_reg;
        d_nxt         = d_reg;
        cnt_nxt       = cnt;
        quotient_nxt  = quotient;
        remainder_nxt = remainder;
        dbz_nxt       = div_by_zero;
        busy_nxt      = (state_nxt == RUN);
        done_nxt      = (state_nxt == DONE);
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    if (div_zero) begin
                        quotient_nxt  = '1;
                        remainder_nxt = dividend;
                        dbz_nxt       = 1'b1;
                    end else begin
                        q_nxt   = dividend;
                        r_nxt   = '0;
                        d_nxt   = divisor;
                        cnt_nxt = CNT_W'(WIDTH - 1);
                    end
                end
            end
            RUN: begin
                q_nxt   = q_step;
                r_nxt   = r_step;
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == '0) begin
                    quotient_nxt  = q_step;
                    remainder_nxt = r_step[WIDTH-1:0];
                    dbz_nxt       = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg       <= '0;
            r_reg       <= '0;
            d_reg       <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            q_reg       <= q_nxt;
            r_reg       <= r_nxt;
            d_reg       <= d_nxt;
            cnt         <= cnt_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            quotient    <= quotient_nxt;
            remainder   <= remainder_nxt;
            div_by_zero <= dbz_nxt;
        end
    end

endmodule

// File: tb/tb_divider_seq_8_bit.sv
// Self-checking bench for divider_seq_8_bit: vector table plus hand sequences,
// expected results queued at issue time and popped when done pulses.
module tb_divider_seq_8_bit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       busy, done, div_by_zero;
    logic [7:0] quotient, remainder;

    divider_seq_8_bit #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } vec_t;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         acc;
    } exp_t;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t sb[$];
    int   done_cyc[$];
    vec_t tbl[7];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: pop on done, check result and latency; check busy every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            logic exp_busy;
            if (done) begin
                done_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL spurious_done: got done=1, expected no done (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("quotient", int'(quotient), int'(e.q));
                    check("remainder", int'(remainder), int'(e.r));
                    check("div_by_zero", int'(div_by_zero), int'(e.dz));
                    check("latency", cyc - e.acc, e.dz ? 0 : 8);
                end
            end
            exp_busy = (sb.size() > 0) && !sb[0].dz && (cyc >= sb[0].acc) && (cyc < sb[0].acc + 8);
            check("busy", int'(busy), int'(exp_busy));
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: got busy=1 after %0d cycles, expected 0", n);
        end
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input logic edz);
        wait_idle();
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sb.push_back('{eq, er, edz, cyc + 1});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", sb.size(), 0);
    endtask

    initial begin
        int divs[6];
        logic [7:0] a, b;

        tbl[0] = '{8'd200, 8'd7,   8'd28,  8'd4, 1'b0};
        tbl[1] = '{8'd255, 8'd1,   8'd255, 8'd0, 1'b0};
        tbl[2] = '{8'd5,   8'd9,   8'd0,   8'd5, 1'b0};
        tbl[3] = '{8'd0,   8'd3,   8'd0,   8'd0, 1'b0};
        tbl[4] = '{8'd255, 8'd255, 8'd1,   8'd0, 1'b0};
        tbl[5] = '{8'd100, 8'd3,   8'd33,  8'd1, 1'b0};
        tbl[6] = '{8'd42,  8'd0,   8'hFF,  8'd42, 1'b1};
        divs = '{1, 2, 3, 7, 128, 255};

        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_quotient", int'(quotient), 0);
        check("rst_remainder", int'(remainder), 0);
        check("rst_div_by_zero", int'(div_by_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            issue(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz);
        end
        drain();

        // Divide by zero, then a normal divide accepted in the DONE cycle clears the flag.
        issue(8'd17, 8'd0, 8'hFF, 8'd17, 1'b1);
        issue(8'd9, 8'd3, 8'd3, 8'd0, 1'b0);
        drain();

        // Back-to-back: done must pulse every 9 cycles.
        done_cyc.delete();
        issue(8'd123, 8'd10, 8'd12, 8'd3, 1'b0);
        issue(8'd77, 8'd77, 8'd1, 8'd0, 1'b0);
        issue(8'd250, 8'd16, 8'd15, 8'd10, 1'b0);
        drain();
        check("b2b_done_count", done_cyc.size(), 3);
        if (done_cyc.size() == 3) begin
            check("b2b_gap0", done_cyc[1] - done_cyc[0], 9);
            check("b2b_gap1", done_cyc[2] - done_cyc[1], 9);
        end

        // start held high with changing operands while the divide is in flight.
        wait_idle();
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd6;
        sb.push_back('{8'd8, 8'd2, 1'b0, cyc + 1});
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            dividend = 8'($urandom);
            divisor  = 8'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        drain();

        // Asynchronous abort inside the 4th RUN cycle of 100/3.
        issue(8'd100, 8'd3, 8'd33, 8'd1, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_quotient", int'(quotient), 0);
        check("abort_remainder", int'(remainder), 0);
        check("abort_div_by_zero", int'(div_by_zero), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        done_cyc.delete();
        repeat (12) @(negedge clk);
        check("abort_no_done", done_cyc.size(), 0);
        issue(8'd100, 8'd3, 8'd33, 8'd1, 1'b0);
        drain();

        // Every dividend against a set of divisors, then random pairs.
        for (int d = 0; d < 6; d++) begin
            for (int x = 0; x < 256; x++) begin
                a = 8'(x);
                b = 8'(divs[d]);
                issue(a, b, 8'(x / divs[d]), 8'(x % divs[d]), 1'b0);
            end
        end
        for (int k = 0; k < 1000; k++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            issue(a, b, a / b, a % b, 1'b0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
